// File: rtl/ai_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : ai_accel_pkg
//  Description: Shared definitions for the AI accelerator and its Wishbone
//               master: operand width, memory map indices, start word and
//               the master sequencing states.
//  Revision   : 1.0 - initial release
// ============================================================================
package ai_accel_pkg;

  // Width of one operand / result word on the streams.
  localparam int TYPE_BW      = 8;
  // Accelerator word map: operands occupy [0, IN_MEM_SIZE), results follow.
  localparam int IN_MEM_SIZE  = 16;
  localparam int OUT_MEM_SIZE = 16;
  // Word index 5 is the "go" register and is never used for operands.
  localparam int GO_INDEX     = 5;
  localparam logic [31:0] GO_WORD = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WR_REQ = 4'd1,
    ST_WR_GAP = 4'd2,
    ST_GO_REQ = 4'd3,
    ST_GO_GAP = 4'd4,
    ST_RD_REQ = 4'd5,
    ST_RD_OUT = 4'd6,
    ST_RD_GAP = 4'd7,
    ST_FIN    = 4'd8
  } master_state_t;

  // Map operand number k to its word index, stepping over the go register.
  function automatic logic [8:0] stream_index(input logic [7:0] k);
    return (k < 8'(GO_INDEX)) ? {1'b0, k} : ({1'b0, k} + 9'd1);
  endfunction

  // Byte address of a word index relative to the accelerator base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [8:0]  idx);
    return base + {21'd0, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ai_accel_wb_master_xfer.sv
`default_nettype none
// ============================================================================
//  Module     : wb_single_xfer
//  Description: One Wishbone classic transfer: raise cyc/stb with captured
//               address/we/data, hold until ack, then drop. Optional ack
//               timeout when AI_MASTER_TIMEOUT_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
module wb_single_xfer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch,
  input  logic [31:0] launch_addr,
  input  logic        launch_we,
  input  logic [31:0] launch_data,
  input  logic        ack,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        finish,
  output logic        timed_out
);

  logic active;

  assign cyc = active;
  assign stb = active;

`ifdef AI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Count cycles spent with the transfer raised; restarts on every launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!active && launch) begin
      wait_cnt <= '0;
    end else if (active) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // An ack in the last allowed cycle still wins over the timeout.
  assign timed_out = active && !ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  assign finish = active && (ack || timed_out);

  // Capture the request on launch, hold it stable, release on ack/timeout.
  // Acks arriving while idle are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      data   <= '0;
    end else if (active) begin
      if (ack || timed_out) begin
        active <= 1'b0;
      end
    end else if (launch) begin
      active <= 1'b1;
      we     <= launch_we;
      addr   <= launch_addr;
      data   <= launch_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ai_accel_wb_master.sv
`default_nettype none
// ============================================================================
//  Module     : ai_accel_wb_master
//  Description: Job sequencer for the AI accelerator. Streams operands into
//               the accelerator over Wishbone, writes the go word, then reads
//               results back onto an output stream.
//               Optional macro: AI_MASTER_TIMEOUT_EN (per-transfer ack
//               timeout with sticky error flag).
//  Revision   : 1.0 - initial release
// ============================================================================
module ai_accel_wb_master
  import ai_accel_pkg::*;
#(
  parameter logic [31:0] ADDR_OFFSET    = 32'h3010_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic [7:0]         in_count,
  input  logic [7:0]         out_count,
  input  logic [TYPE_BW-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [TYPE_BW-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [31:0]        wb_addr_o,
  output logic [31:0]        wb_data_o,
  input  logic [31:0]        wb_data_i,
  input  logic               wb_ack_i
);

  master_state_t      state, state_nxt;
  logic [7:0]         in_cnt, out_cnt;
  logic [7:0]         wr_k, rd_j;
  logic               issued;
  logic [TYPE_BW-1:0] out_data_q;

  logic               launch, launch_we;
  logic [31:0]        launch_addr, launch_data;
  logic               xfer_finish, xfer_timeout;
  logic               job_start;

  // Only the result bits of the read bus are consumed.
  logic unused_rdata_bits;
  assign unused_rdata_bits = ^wb_data_i[31:TYPE_BW];

  assign job_start = (state == ST_IDLE) && start;
  assign out_data  = out_data_q;

  wb_single_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .launch     (launch),
    .launch_addr(launch_addr),
    .launch_we  (launch_we),
    .launch_data(launch_data),
    .ack        (wb_ack_i),
    .cyc        (wb_cyc_o),
    .stb        (wb_stb_o),
    .we         (wb_we_o),
    .addr       (wb_addr_o),
    .data       (wb_data_o),
    .finish     (xfer_finish),
    .timed_out  (xfer_timeout)
  );

  // Next state, transfer requests and stream handshakes.
  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    launch_we   = 1'b1;
    launch_addr = word_addr(ADDR_OFFSET, stream_index(wr_k));
    launch_data = {{(32-TYPE_BW){1'b0}}, in_data};
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state != ST_IDLE) && (state != ST_FIN);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (in_count == 8'd0) ? ST_GO_REQ : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        in_ready = !issued;
        launch   = in_valid && !issued;
        if (xfer_timeout)     state_nxt = ST_FIN;
        else if (xfer_finish) state_nxt = ST_WR_GAP;
      end
      ST_WR_GAP: begin
        state_nxt = (wr_k == in_cnt) ? ST_GO_REQ : ST_WR_REQ;
      end
      ST_GO_REQ: begin
        launch      = !issued;
        launch_addr = word_addr(ADDR_OFFSET, 9'(GO_INDEX));
        launch_data = GO_WORD;
        if (xfer_timeout)     state_nxt = ST_FIN;
        else if (xfer_finish) state_nxt = ST_GO_GAP;
      end
      ST_GO_GAP: begin
        state_nxt = (out_cnt == 8'd0) ? ST_FIN : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        launch      = !issued;
        launch_we   = 1'b0;
        launch_addr = word_addr(ADDR_OFFSET, 9'(IN_MEM_SIZE) + {1'b0, rd_j});
        launch_data = '0;
        if (xfer_timeout)     state_nxt = ST_FIN;
        else if (xfer_finish) state_nxt = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_RD_GAP;
      end
      ST_RD_GAP: begin
        state_nxt = (rd_j == out_cnt) ? ST_FIN : ST_RD_REQ;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Job counts, operand/result counters and the one-launch-per-state flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      wr_k    <= '0;
      rd_j    <= '0;
      issued  <= 1'b0;
    end else begin
      if (job_start) begin
        in_cnt  <= in_count;
        out_cnt <= out_count;
        wr_k    <= '0;
        rd_j    <= '0;
      end
      if (launch)           issued <= 1'b1;
      else if (xfer_finish) issued <= 1'b0;
      if (state == ST_WR_REQ && xfer_finish && !xfer_timeout) wr_k <= wr_k + 8'd1;
      if (state == ST_RD_OUT && out_ready)                    rd_j <= rd_j + 8'd1;
    end
  end

  // Register the result word when its read is acknowledged.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_data_q <= '0;
    end else if (state == ST_RD_REQ && xfer_finish && !xfer_timeout) begin
      out_data_q <= wb_data_i[TYPE_BW-1:0];
    end
  end

`ifdef AI_MASTER_TIMEOUT_EN
  logic error_q;

  // Sticky timeout flag, cleared by reset or the next accepted start.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)          error_q <= 1'b0;
    else if (job_start)    error_q <= 1'b0;
    else if (xfer_timeout) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ai_accel_wb_master.sv
`default_nettype none
// ============================================================================
//  Module     : tb_ai_accel_wb_master
//  Description: Self-checking bench for ai_accel_wb_master with a Wishbone
//               slave model and a transfer-list reference model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_ai_accel_wb_master;
  import ai_accel_pkg::*;

  localparam logic [31:0] OFF = 32'h3010_0000;
  localparam int          TMO = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         in_count = '0, out_count = '0;
  logic [TYPE_BW-1:0] in_data = '0;
  logic               in_valid = 1'b0, in_ready;
  logic [TYPE_BW-1:0] out_data;
  logic               out_valid, out_ready = 1'b0;
  logic               busy, done, error;
  logic               wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]        wb_addr_o, wb_data_o;
  logic [31:0]        wb_data_i = '0;
  logic               ack = 1'b0, stray_ack = 1'b0;

  always #5 clk = ~clk;

  ai_accel_wb_master #(.ADDR_OFFSET(OFF), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .in_count(in_count),
    .out_count(out_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .error(error),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
    .wb_ack_i(ack | stray_ack)
  );

  int tests = 0, fails = 0;

  // ---------------- Wishbone slave model ----------------
  bit          slave_en = 1'b1;
  int          ack_delay = 2;
  int          first_rd_delay = -1;
  int          rd_seen, wait_cnt, sl_d;
  int          hold_viol, gap_viol, ctl_viol;
  bit          in_xfer;
  logic [31:0] held_addr, held_data, sl_idx;
  logic        held_we;
  logic [31:0] rd_mem [0:63];
  logic [31:0] obs_addr[$], obs_data[$];
  logic        obs_we[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_we[$];
  logic [7:0]  words [0:15];

  always @(negedge clk) begin
    if (wb_cyc_o !== wb_stb_o) ctl_viol++;
    if (ack) begin
      ack = 1'b0;
      if (wb_cyc_o) gap_viol++;
      wait_cnt = 0;
      in_xfer  = 1'b0;
    end else if (wb_cyc_o) begin
      if (!in_xfer) begin
        in_xfer = 1'b1; held_addr = wb_addr_o; held_we = wb_we_o; held_data = wb_data_o;
        wait_cnt = 0;
      end else if (wb_addr_o !== held_addr || wb_we_o !== held_we || wb_data_o !== held_data) begin
        hold_viol++;
      end
      sl_d = (!wb_we_o && rd_seen == 0 && first_rd_delay >= 0) ? first_rd_delay : ack_delay;
      if (slave_en && wait_cnt >= sl_d) begin
        ack = 1'b1;
        sl_idx = ((wb_addr_o - OFF) >> 2) & 32'd63;
        wb_data_i = rd_mem[sl_idx];
        obs_addr.push_back(wb_addr_o);
        obs_we.push_back(wb_we_o);
        obs_data.push_back(wb_data_o);
        if (!wb_we_o) rd_seen++;
      end else begin
        wait_cnt++;
      end
    end else begin
      in_xfer  = 1'b0;
      wait_cnt = 0;
    end
  end

  // ---------------- Reference model: expected transfer list ----------------
  function automatic void build_model(input int n_in, input int n_out);
    int idx;
    exp_addr.delete(); exp_we.delete(); exp_data.delete();
    for (int k = 0; k < n_in; k++) begin
      idx = (k < 5) ? k : k + 1;
      exp_addr.push_back(OFF + 32'(4 * idx));
      exp_we.push_back(1'b1);
      exp_data.push_back({24'd0, words[k]});
    end
    exp_addr.push_back(OFF + 32'd20);
    exp_we.push_back(1'b1);
    exp_data.push_back(32'hFFFF_FFFF);
    for (int j = 0; j < n_out; j++) begin
      exp_addr.push_back(OFF + 32'(4 * (IN_MEM_SIZE + j)));
      exp_we.push_back(1'b0);
      exp_data.push_back(32'd0);
    end
  endfunction

  task automatic drive_words(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      in_data  = words[k];
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 3000) begin @(negedge clk); t++; end
      if (!in_ready) begin
        tests++; fails++;
        $display("FAIL in_ready_wait word %0d: in_ready=%b required 1", k, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic consume(input int n);
    int t, hold; bit bad; logic [7:0] first;
    for (int j = 0; j < n; j++) begin
      t = 0;
      while (!out_valid && t < 3000) begin @(negedge clk); t++; end
      tests++;
      if (!out_valid) begin
        fails++;
        $display("FAIL out_valid_wait word %0d: out_valid=%b required 1", j, out_valid);
        return;
      end
      if (out_data !== rd_mem[IN_MEM_SIZE + j][7:0]) begin
        fails++;
        $display("FAIL out_data word %0d: got %0d required %0d", j, out_data, rd_mem[IN_MEM_SIZE + j][7:0]);
      end
      hold = $urandom_range(1, 4); first = out_data; bad = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || out_data !== first || wb_cyc_o) bad = 1'b1;
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL out_hold word %0d: out_valid=%b cyc=%b data=%0d required 1/0/%0d", j, out_valid, wb_cyc_o, out_data, first);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic run_job(input int n_in, input int n_out, input bit glitch, input string tag);
    int done_cnt, t, n14;
    obs_addr.delete(); obs_we.delete(); obs_data.delete();
    hold_viol = 0; gap_viol = 0; ctl_viol = 0; rd_seen = 0;
    build_model(n_in, n_out);
    @(negedge clk);
    start = 1'b1; in_count = 8'(n_in); out_count = 8'(n_out);
    @(negedge clk);
    start = 1'b0; in_count = 8'($urandom); out_count = 8'($urandom);
    done_cnt = 0;
    fork
      drive_words(n_in);
      consume(n_out);
      begin
        if (glitch) begin
          repeat (4) @(negedge clk);
          if (busy) begin
            start = 1'b1; in_count = 8'd3; out_count = 8'd1;
            @(negedge clk);
            start = 1'b0;
          end
        end
      end
      begin
        t = 0;
        while (done_cnt == 0 && t < 8000) begin
          @(negedge clk); t++;
          if (done) done_cnt++;
        end
      end
    join
    repeat (3) begin @(negedge clk); if (done) done_cnt++; end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL %s done_count: got %0d required 1", tag, done_cnt); end
    tests++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      fails++; $display("FAIL %s idle_flags: busy=%b error=%b required 0/0", tag, busy, error);
    end
    tests++;
    if (obs_addr.size() != exp_addr.size()) begin
      fails++;
      $display("FAIL %s xfer_count: got %0d required %0d", tag, obs_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        tests++;
        if (obs_addr[i] !== exp_addr[i] || obs_we[i] !== exp_we[i] ||
            (exp_we[i] && obs_data[i] !== exp_data[i])) begin
          fails++;
          $display("FAIL %s xfer %0d: addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                   tag, i, obs_addr[i], obs_we[i], obs_data[i], exp_addr[i], exp_we[i], exp_data[i]);
        end
      end
    end
    n14 = 0;
    foreach (obs_addr[i]) if (obs_addr[i] == OFF + 32'h14) n14++;
    tests++;
    if (n14 != 1) begin fails++; $display("FAIL %s go_index_writes: got %0d required 1", tag, n14); end
    tests++;
    if (hold_viol != 0 || gap_viol != 0 || ctl_viol != 0) begin
      fails++;
      $display("FAIL %s protocol: hold=%0d gap=%0d ctl=%0d required 0/0/0", tag, hold_viol, gap_viol, ctl_viol);
    end
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      fails++; $display("FAIL reset_ctl: cyc/stb/we=%b required 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    tests++;
    if (wb_addr_o !== 32'd0 || wb_data_o !== 32'd0) begin
      fails++; $display("FAIL reset_bus: addr=%h data=%h required 0/0", wb_addr_o, wb_data_o);
    end
    tests++;
    if ({in_ready, out_valid, busy, done, error} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: rdy/vld/busy/done/err=%b required 00000", {in_ready, out_valid, busy, done, error});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_write();
    words[0] = 8'd7; words[1] = 8'hFE; words[2] = 8'd9;
    ack_delay = 2;
    run_job(3, 0, 1'b0, "spec_write");
  endtask

  task automatic test_skip_go_index();
    for (int k = 0; k < 7; k++) words[k] = 8'($urandom);
    ack_delay = 1;
    run_job(7, 0, 1'b0, "skip_go_index");
  endtask

  task automatic test_read_stall();
    words[0] = 8'($urandom); words[1] = 8'($urandom);
    rd_mem[IN_MEM_SIZE]     = 32'h0000_0015;
    rd_mem[IN_MEM_SIZE + 1] = $urandom;
    ack_delay = 0; first_rd_delay = 40;
    run_job(2, 2, 1'b0, "read_stall");
    first_rd_delay = -1;
  endtask

  task automatic test_random_jobs();
    int ni, no;
    for (int r = 0; r < 6; r++) begin
      ni = $urandom_range(0, 12); no = $urandom_range(0, 4);
      for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
      for (int m = 0; m < 64; m++) rd_mem[m] = $urandom;
      ack_delay = $urandom_range(0, 4);
      run_job(ni, no, 1'b0, "random");
    end
  endtask

  task automatic test_start_midjob();
    for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
    ack_delay = 2;
    run_job(8, 2, 1'b1, "start_midjob");
  endtask

  task automatic test_stray_ack();
    bit bad = 1'b0;
    @(negedge clk); stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (wb_cyc_o || busy || done || out_valid) bad = 1'b1;
    end
    stray_ack = 1'b0;
    tests++;
    if (bad) begin fails++; $display("FAIL stray_ack: cyc=%b busy=%b done=%b required 0/0/0", wb_cyc_o, busy, done); end
  endtask

  task automatic test_mid_reset();
    int t = 0, dn = 0;
    ack_delay = 30;
    @(negedge clk); start = 1'b1; in_count = 8'd0; out_count = 8'd2;
    @(negedge clk); start = 1'b0;
    while (!wb_stb_o && t < 100) begin @(negedge clk); t++; end
    tests++;
    if (!wb_stb_o) begin fails++; $display("FAIL mid_reset_raise: stb=%b required 1", wb_stb_o); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mid_reset: cyc=%b stb=%b busy=%b done=%b required 0000", wb_cyc_o, wb_stb_o, busy, done);
    end
    rst = 1'b0;
    repeat (40) begin @(negedge clk); if (done || wb_cyc_o) dn++; end
    tests++;
    if (dn != 0) begin fails++; $display("FAIL mid_reset_quiet: activity cycles=%0d required 0", dn); end
    ack_delay = 2;
  endtask

  task automatic test_timeout();
    int t = 0, hi = 0;
    bit dn = 1'b0;
    slave_en = 1'b0;
    @(negedge clk); start = 1'b1; in_count = 8'd0; out_count = 8'd0;
    @(negedge clk); start = 1'b0;
    while (!wb_stb_o && t < 100) begin @(negedge clk); t++; end
    while (wb_stb_o && hi < 1100) begin hi++; @(negedge clk); end
`ifdef AI_MASTER_TIMEOUT_EN
    tests++;
    if (hi != TMO) begin fails++; $display("FAIL timeout_len: stb high %0d cycles required %0d", hi, TMO); end
    for (int i = 0; i < 4; i++) begin
      if (done) dn = 1'b1;
      if (!dn) @(negedge clk);
    end
    tests++;
    if (!dn || error !== 1'b1) begin fails++; $display("FAIL timeout_flags: done_seen=%b error=%b required 1/1", dn, error); end
    repeat (5) @(negedge clk);
    tests++;
    if (error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: error=%b required 1", error); end
    slave_en = 1'b1;
    words[0] = 8'($urandom);
    run_job(1, 0, 1'b0, "after_timeout");
`else
    tests++;
    if (hi < 1000 || !wb_stb_o || error !== 1'b0) begin
      fails++; $display("FAIL no_timeout: stb high %0d cycles stb=%b error=%b required >=1000/1/0", hi, wb_stb_o, error);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    slave_en = 1'b1;
`endif
  endtask

  initial begin
    for (int m = 0; m < 64; m++) rd_mem[m] = $urandom;
    for (int k = 0; k < 16; k++) words[k] = 8'($urandom);
    test_reset();
    test_spec_write();
    test_skip_go_index();
    test_read_stall();
    test_random_jobs();
    test_start_midjob();
    test_stray_ack();
    test_mid_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
